// File: rtl/mem_banked_pkg.sv
// Shared types and helpers for the banked memory.
// MEM_BANKED_WSTRB_EN adds a byte-strobe field to the request record.
package mem_pkg;

   localparam int MEM_DATA_W    = 32;
   localparam int MEM_ADDR_W    = 8;
   localparam int MEM_NUM_BANKS = 4;

   // Bank-select bits; a single bank needs no select bits at all.
   function automatic int bank_bits(input int n);
      return (n > 1) ? $clog2(n) : 0;
   endfunction

   localparam int BANK_BITS = bank_bits(MEM_NUM_BANKS);

   typedef enum logic {BANK_IDLE, BANK_BUSY} bank_state_e;

   typedef struct packed {
      logic                    we;
      logic [MEM_ADDR_W-1:0]   addr;
      logic [MEM_DATA_W-1:0]   wdata;
`ifdef MEM_BANKED_WSTRB_EN
      logic [MEM_DATA_W/8-1:0] wstrb;
`endif
   } mem_req_t;

endpackage

// File: rtl/mem_banked_bank.sv
// One memory bank: local storage, busy FSM and latency counter.
// MEM_BANKED_WSTRB_EN enables byte-masked writes at completion.
module mem_bank import mem_pkg::*; #(
   parameter int DATA_WIDTH    = MEM_DATA_W,
   parameter int ADDRESS_WIDTH = MEM_ADDR_W,
   parameter int NUM_BANKS     = MEM_NUM_BANKS,
   parameter int LATENCY       = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  acc,
   input  mem_req_t              req,
   output logic                  idle,
   output logic                  done,
   output logic                  we,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int BB    = bank_bits(NUM_BANKS);
   localparam int DEPTH = (2 ** ADDRESS_WIDTH) / NUM_BANKS;
   localparam int LAW   = (ADDRESS_WIDTH > BB) ? ADDRESS_WIDTH - BB : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   bank_state_e            state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   mem_req_t               req_q, req_d;
   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
   logic [ADDRESS_WIDTH-1:0] addr_sh;
   logic [LAW-1:0]         row;
   logic [DATA_WIDTH-1:0]  wr_word;
   logic                   unused_addr;

   // Low address bits picked the bank; the rest index this bank's rows.
   assign addr_sh     = req_q.addr >> BB;
   assign row         = addr_sh[LAW-1:0];
   assign unused_addr = ^addr_sh;

   assign done  = (state_q == BANK_BUSY) && (cnt_q == '0);
   // A completing bank can take the next request on the same edge.
   assign idle  = (state_q == BANK_IDLE) || done;
   assign we    = req_q.we;
   assign rdata = mem_q[row];

   // Merge write data with the stored word according to the strobes.
   always_comb begin
      wr_word = req_q.wdata;
`ifdef MEM_BANKED_WSTRB_EN
      for (int b = 0; b < DATA_WIDTH / 8; b++)
         if (!req_q.wstrb[b]) wr_word[8*b +: 8] = mem_q[row][8*b +: 8];
`endif
   end

   // Busy FSM: count down LATENCY-1..0, then complete and go idle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      case (state_q)
         BANK_BUSY: begin
            if (cnt_q == '0) state_d = BANK_IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = BANK_IDLE;
      endcase
      if (acc && idle) begin
         state_d = BANK_BUSY;
         cnt_d   = CNT_W'(LATENCY - 1);
         req_d   = req;
      end
   end

   // Control state; reset drops any in-flight access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BANK_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
      end
   end

   // Storage is written only on a completing write; contents survive reset.
   always_ff @(posedge clk) begin
      if (!rst && done && req_q.we) mem_q[row] <= wr_word;
   end

endmodule

// File: rtl/mem_banked.sv
// Banked fixed-latency memory top: bank decode, req_ready, response regs.
// Define MEM_BANKED_WSTRB_EN to add the req_wstrb byte-strobe port.
module mem_banked import mem_pkg::*; #(
   parameter int DATA_WIDTH    = MEM_DATA_W,
   parameter int ADDRESS_WIDTH = MEM_ADDR_W,
   parameter int NUM_BANKS     = MEM_NUM_BANKS,
   parameter int LATENCY       = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [ADDRESS_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
`ifdef MEM_BANKED_WSTRB_EN
   input  logic [DATA_WIDTH/8-1:0]  req_wstrb,
`endif
   output logic                     resp_valid,
   output logic                     resp_we,
   output logic [DATA_WIDTH-1:0]    resp_rdata
);

   logic [NUM_BANKS-1:0]                 bank_idle, bank_done, bank_we;
   logic [NUM_BANKS-1:0]                 bank_sel, bank_acc;
   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;
   logic [ADDRESS_WIDTH-1:0]             sel_addr;
   mem_req_t                             req;

   logic                  resp_valid_q, resp_valid_d;
   logic                  resp_we_q, resp_we_d;
   logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic                  done_we;
   logic [DATA_WIDTH-1:0] done_rdata;

   assign sel_addr = req_addr & ADDRESS_WIDTH'(NUM_BANKS - 1);

   // Bundle the request for capture by the selected bank.
   always_comb begin
      req       = '0;
      req.we    = req_we;
      req.addr  = req_addr;
      req.wdata = req_wdata;
`ifdef MEM_BANKED_WSTRB_EN
      req.wstrb = req_wstrb;
`endif
   end

   // Decode target bank; ready only reflects that bank being free.
   always_comb begin
      bank_sel  = '0;
      req_ready = 1'b0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         bank_sel[i] = (sel_addr == ADDRESS_WIDTH'(i));
         if (bank_sel[i] && bank_idle[i] && !rst) req_ready = 1'b1;
      end
      bank_acc = bank_sel & {NUM_BANKS{req_valid & req_ready}};
   end

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      mem_bank #(
         .DATA_WIDTH   (DATA_WIDTH),
         .ADDRESS_WIDTH(ADDRESS_WIDTH),
         .NUM_BANKS    (NUM_BANKS),
         .LATENCY      (LATENCY)
      ) u_bank (
         .clk  (clk),
         .rst  (rst),
         .acc  (bank_acc[g]),
         .req  (req),
         .idle (bank_idle[g]),
         .done (bank_done[g]),
         .we   (bank_we[g]),
         .rdata(bank_rdata[g])
      );
   end

   // One-hot OR mux from the completing bank; read data held otherwise.
   always_comb begin
      done_we    = 1'b0;
      done_rdata = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (bank_done[i]) begin
            done_we    = done_we | bank_we[i];
            done_rdata = done_rdata | bank_rdata[i];
         end
      end
      resp_valid_d = |bank_done;
      resp_we_d    = resp_valid_d & done_we;
      resp_rdata_d = (resp_valid_d && !done_we) ? done_rdata : resp_rdata_q;
   end

   // Response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid_q <= 1'b0;
         resp_we_q    <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_we_q    <= resp_we_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_we    = resp_we_q;
   assign resp_rdata = resp_rdata_q;

`ifndef SYNTHESIS
   // Shared latency means completions can never collide.
   a_one_done: assert property (@(posedge clk) disable iff (rst) $onehot0(bank_done));
`endif

endmodule
